serial_pattern_gen: RTL and testbench
=====================================

SERIAL_PATTERN_GEN -- requirements
Module: serial_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 8, maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 4, width of length/index fields; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 load  input  1  capture pattern and length.
REQ-006 pattern  input  WIDTH  bits to transmit, MSB of the active field first.
REQ-007 length  input  CNT_W  number of bits to transmit, legal range 1..WIDTH.
REQ-008 start  input  1  begin transmission of the captured pattern.
REQ-009 stop  input  1  abort transmission.
REQ-010 repeat_en  input  1  loop the pattern continuously while high.
REQ-011 w_out  output  1  serial bit feeding the sequence detector's w input.
REQ-012 w_valid  output  1  high when w_out carries a pattern bit.
REQ-013 busy  output  1  high in SHIFT state.
REQ-014 done  output  1  one-cycle pulse after the last bit of a non-repeating run.
REQ-015 state  output  2  current FSM state, for LEDR display.

Function
REQ-016 FSM states SHALL be IDLE=2'b00, READY=2'b01, SHIFT=2'b10, DONE=2'b11.
REQ-017 IDLE/READY: load with 1 <= length <= WIDTH SHALL capture pattern and length, next state READY.
REQ-018 load with length 0 or length > WIDTH SHALL be ignored; state and captured data unchanged.
REQ-019 READY: start (load low) SHALL set index = length-1, next state SHIFT.
REQ-020 load and start high together in READY: load wins, state stays READY, start dropped.
REQ-021 start in IDLE, SHIFT or DONE SHALL be ignored.
REQ-022 SHIFT: w_out = captured_pattern[index], w_valid = 1, one bit per cycle; first bit appears in the cycle after the edge that sampled start.
REQ-023 SHIFT, index > 0: index decrements by 1 each cycle.
REQ-024 SHIFT, index == 0, repeat_en high: index reloads to length-1, stays SHIFT with no gap cycle.
REQ-025 SHIFT, index == 0, repeat_en low: next state DONE.
REQ-026 DONE: done = 1 for exactly that cycle, w_valid = 0, next state READY; captured pattern retained.
REQ-027 SHIFT: stop SHALL force next state READY without passing through DONE; no done pulse; stop wins over index==0 transitions.
REQ-028 load during SHIFT or DONE SHALL be ignored.
REQ-029 Outside SHIFT: w_out = 0, w_valid = 0, busy = 0.
REQ-030 Outputs SHALL be decoded from registered state and index only (no input-to-output combinational path).

Reset
REQ-031 reset high at a rising edge SHALL force state IDLE, index 0, captured pattern 0, captured length 0, in any state including mid-SHIFT.
REQ-032 Reset values: w_out 0, w_valid 0, busy 0, done 0, state 2'b00.
REQ-033 reset SHALL take priority over load, start and stop.

Structure
REQ-034 State encodings IDLE/READY/SHIFT/DONE SHALL be localparams in a shared package, reused by LEDR display logic.
REQ-035 One sub-module is natural: bit_index_counter (loadable down-counter, CNT_W wide, zero flag).
REQ-036 Next-state logic, state registers and output decode SHALL be separate blocks.

Verification
REQ-037 load pattern=8'b1011_0000, length=4, start -> w_out 0,0,0,0 (pattern[3:0] MSB-first) with w_valid high 4 cycles, then done pulse 1 cycle, state 01.
REQ-038 load pattern=8'b0000_0110, length=3, repeat_en=1, start -> w_out 1,1,0,1,1,0,... continuous, w_valid never drops, no done.
REQ-039 load with length=0 from IDLE -> state stays 00; subsequent start ignored, w_valid stays 0.
REQ-040 length=8 pattern=8'hB1, stop asserted on 3rd bit cycle -> w_out 1,0,1 then w_valid 0, state 01, done never pulses.
REQ-041 reset asserted during SHIFT bit 2 of 8 -> next cycle state 00, all outputs 0; start without new load ignored.
REQ-042 load of new pattern during SHIFT -> ignored, original bit sequence completes unchanged; load and start together in READY -> stays READY.

Source files
------------

// File: rtl/serial_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator: FSM state encodings
// that the LEDR display logic decodes as well.
package serial_pattern_gen_pkg;

    localparam logic [1:0] StateIdle  = 2'b00;
    localparam logic [1:0] StateReady = 2'b01;
    localparam logic [1:0] StateShift = 2'b10;
    localparam logic [1:0] StateDone  = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = StateIdle,
        StReady = StateReady,
        StShift = StateShift,
        StDone  = StateDone
    } state_e;

endpackage

// File: rtl/serial_pattern_gen_bit_index_counter.sv
// Loadable down-counter that selects the pattern bit being shifted out.
// Load has priority over decrement.
module bit_index_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/serial_pattern_gen.sv
// Captures a pattern of 1..WIDTH bits and shifts it out MSB-first, one bit per
// cycle, optionally looping. Outputs decode only registered state and index.
module serial_pattern_gen
    import serial_pattern_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic [CNT_W-1:0] length_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             repeat_en_i,
    output logic             w_out_o,
    output logic             w_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       state_o
);

    localparam logic [CNT_W-1:0] WidthCnt = CNT_W'(WIDTH);

    state_e           state_d, state_q;
    logic [WIDTH-1:0] pat_d, pat_q;
    logic [CNT_W-1:0] len_d, len_q;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val, idx;
    logic [WIDTH-1:0] pat_shifted;
    logic             load_ok;

    assign load_ok = load_i && (length_i != '0) && (length_i <= WidthCnt);

    bit_index_counter #(
        .CNT_W (CNT_W)
    ) u_bit_index_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .count_o    (idx),
        .zero_o     (cnt_zero)
    );

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        len_d        = len_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = len_q - 1'b1;
        unique case (state_q)
            StIdle: begin
                if (load_ok) begin
                    pat_d   = pattern_i;
                    len_d   = length_i;
                    state_d = StReady;
                end
            end
            StReady: begin
                // A load request blocks start even when its length is rejected.
                if (load_i) begin
                    if (load_ok) begin
                        pat_d = pattern_i;
                        len_d = length_i;
                    end
                end else if (start_i) begin
                    cnt_load = 1'b1;
                    state_d  = StShift;
                end
            end
            StShift: begin
                if (stop_i) begin
                    state_d = StReady;
                end else if (cnt_zero) begin
                    if (repeat_en_i) begin
                        cnt_load = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StDone: begin
                state_d = StReady;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            pat_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
        end
    end

    assign pat_shifted = pat_q >> idx;

    // Output decode
    always_comb begin
        w_out_o   = 1'b0;
        w_valid_o = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        state_o   = state_q;
        if (state_q == StShift) begin
            w_out_o   = pat_shifted[0];
            w_valid_o = 1'b1;
            busy_o    = 1'b1;
        end
        if (state_q == StDone) begin
            done_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen: a vector table plus hand-written
// sequences for looping and mid-shift reset.
module tb_serial_pattern_gen;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] pattern;
    logic [3:0] length;
    logic       start;
    logic       stop;
    logic       repeat_en;
    logic       w_out;
    logic       w_valid;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    serial_pattern_gen #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (load),
        .pattern_i   (pattern),
        .length_i    (length),
        .start_i     (start),
        .stop_i      (stop),
        .repeat_en_i (repeat_en),
        .w_out_o     (w_out),
        .w_valid_o   (w_valid),
        .busy_o      (busy),
        .done_o      (done),
        .state_o     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output bundles: {w_out, w_valid, busy, done, state}
    localparam logic [5:0] EIdle = 6'b0_0_0_0_00;
    localparam logic [5:0] ERdy  = 6'b0_0_0_0_01;
    localparam logic [5:0] ES0   = 6'b0_1_1_0_10;
    localparam logic [5:0] ES1   = 6'b1_1_1_0_10;
    localparam logic [5:0] EDone = 6'b0_0_0_1_11;

    typedef struct {
        logic       r;
        logic       l;
        logic       s;
        logic       p;
        logic       rp;
        logic [7:0] pat;
        logic [3:0] len;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic l, logic s, logic p, logic rp,
                                logic [7:0] pat, logic [3:0] len, logic [5:0] exp);
        vec_t v;
        v.r = r; v.l = l; v.s = s; v.p = p; v.rp = rp;
        v.pat = pat; v.len = len; v.exp = exp;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic r, logic l, logic s, logic p, logic rp,
                         logic [7:0] pat, logic [3:0] len);
        rst = r; load = l; start = s; stop = p; repeat_en = rp;
        pattern = pat; length = len;
    endtask

    task automatic check(string name, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {2'b00, w_out, w_valid, busy, done, state};
    endfunction

    initial begin
        drive(1, 0, 0, 0, 0, 8'h00, 4'd0);

        // reset, then illegal loads and an ignored start from IDLE
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 4'd0, EIdle));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'hFF, 4'd0, EIdle));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'hFF, 4'd9, EIdle));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 4'd0, EIdle));
        // B0 len 4: bits 3..0 are all zero, then done, then READY
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'hB0, 4'd4, ERdy));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 4'd0, ES0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 4'd0, ES0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 4'd0, ES0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 4'd0, ES0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 4'd0, EDone));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 4'd0, ERdy));
        // B1 len 8: bits 1,0,1 then stop -> READY, no done
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'hB1, 4'd8, ERdy));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 4'd0, ES1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 4'd0, ES0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 4'd0, ES1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 4'd0, ERdy));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 4'd0, ERdy));
        // load+start in READY: load wins; load during SHIFT ignored
        vecs.push_back(mk(0, 1, 1, 0, 0, 8'h5A, 4'd6, ERdy));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 4'd0, ES0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'hFF, 4'd8, ES1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'hFF, 4'd8, ES1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 4'd0, ES0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 4'd0, ES1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 4'd0, ES0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'hFF, 4'd8, EDone));
        // start while in DONE ignored; a later start replays retained 5A len 6
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 4'd0, ERdy));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 4'd0, ES0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 4'd0, ES1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 4'd0, ERdy));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].l, vecs[i].s, vecs[i].p, vecs[i].rp,
                  vecs[i].pat, vecs[i].len);
            tick();
            check($sformatf("vec%0d", i), outs(), {2'b00, vecs[i].exp});
        end

        // Repeat mode: 06 len 3 loops 1,1,0 with no gap and no done
        begin
            logic [2:0] exp_bits;
            int         done_seen;
            exp_bits = 3'b110;
            drive(1, 0, 0, 0, 0, 8'h00, 4'd0); tick();
            drive(0, 1, 0, 0, 1, 8'h06, 4'd3); tick();
            drive(0, 0, 1, 0, 1, 8'h00, 4'd0); tick();
            drive(0, 0, 0, 0, 1, 8'h00, 4'd0);
            for (int i = 0; i < 9; i++) begin
                check($sformatf("rep_bit%0d", i), outs(),
                      {2'b00, exp_bits[2 - (i % 3)], 5'b1_1_0_10});
                tick();
            end
            // Drop repeat_en: current pass finishes, then a single done pulse
            repeat_en = 1'b0;
            done_seen = 0;
            for (int i = 0; i < 8; i++) begin
                if (done) done_seen++;
                tick();
            end
            check("rep_done_pulses", 8'(done_seen), 8'd1);
            check("rep_end_state", outs(), {2'b00, ERdy});
        end

        // Reset during bit 2 of 8, then start without load is ignored
        drive(0, 1, 0, 0, 0, 8'hB1, 4'd8); tick();
        drive(0, 0, 1, 0, 0, 8'h00, 4'd0); tick();
        drive(0, 0, 0, 0, 0, 8'h00, 4'd0); tick();
        check("rst_pre_bit2", outs(), {2'b00, ES0});
        drive(1, 1, 1, 1, 0, 8'hFF, 4'd8); tick();
        check("rst_mid_shift", outs(), {2'b00, EIdle});
        drive(0, 0, 1, 0, 0, 8'h00, 4'd0); tick();
        check("rst_start_ignored", outs(), {2'b00, EIdle});
        drive(0, 0, 0, 0, 0, 8'h00, 4'd0); tick();
        check("rst_stays_idle", outs(), {2'b00, EIdle});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
